// File: rtl/write_back_stage.sv
// Final RISC-V pipeline stage: selects the retiring result (ALU, extended load
// data or link address) and drives the register-file write port.
module write_back_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc,
  input  logic [1:0]  write_back_type_input,
  input  logic [1:0]  read_status_input,
  input  logic        load_unsigned_input,
  input  logic [4:0]  destination_register_number_input,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_valid,
  output logic [4:0]  destination_register_number,
  output logic [31:0] write_back_data,
  output logic        write_enable,
  output logic        load_error,
  output logic [31:0] retired_count
);

  localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Load descriptor captured at accept, consumed when the data returns
  logic [1:0] ld_off_p1;
  logic [1:0] ld_status_p1;
  logic       ld_unsigned_p1;
  logic [4:0] ld_rd_p1;

  logic        is_load;
  logic        imm_we;
  logic [31:0] imm_data;

  assign in_ready = (state == IDLE);
  assign is_load  = (write_back_type_input == 2'b10) && (read_status_input != 2'b00);
  assign imm_we   = (write_back_type_input[0] == 1'b1) &&
                    (destination_register_number_input != 5'd0);

  always_comb begin
    imm_data = 32'd0;
    case (write_back_type_input)
      2'b01:   imm_data = alu_result;
      2'b11:   imm_data = pc + 32'd4;
      default: imm_data = 32'd0;
    endcase
  end

  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  status,
                                               input logic        uns);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] res;
    b   = 8'(word >> {off, 3'b000});
    h   = off[1] ? word[31:16] : word[15:0];
    res = word;
    case (status)
      2'b01:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b10:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid && is_load) begin
      ld_off_p1      <= alu_result[1:0];
      ld_status_p1   <= read_status_input;
      ld_unsigned_p1 <= load_unsigned_input;
      ld_rd_p1       <= destination_register_number_input;
    end
  end

  // Write-back register: outputs update one cycle after accept or load return
  always_ff @(posedge clk) begin
    if (rst) begin
      state                       <= IDLE;
      wait_cnt                    <= '0;
      destination_register_number <= 5'd0;
      write_back_data             <= 32'd0;
      write_enable                <= 1'b0;
      load_error                  <= 1'b0;
      retired_count               <= 32'd0;
    end else begin
      write_enable                <= 1'b0;
      destination_register_number <= 5'd0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_load) begin
              state    <= WAIT_LOAD;
              wait_cnt <= '0;
            end else begin
              write_enable                <= imm_we;
              destination_register_number <= imm_we ? destination_register_number_input : 5'd0;
              write_back_data             <= imm_data;
              retired_count               <= retired_count + 32'd1;
            end
          end
        end
        WAIT_LOAD: begin
          if (mem_read_valid) begin
            write_enable                <= (ld_rd_p1 != 5'd0);
            destination_register_number <= ld_rd_p1;
            write_back_data             <= extract_load(mem_read_data, ld_off_p1,
                                                        ld_status_p1, ld_unsigned_p1);
            retired_count               <= retired_count + 32'd1;
            state                       <= IDLE;
          end else if (wait_cnt == CNT_W'(LOAD_TIMEOUT - 2)) begin
            // The increment would reach LOAD_TIMEOUT-1: abandon the load
            load_error    <= 1'b1;
            retired_count <= retired_count + 32'd1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage: drivers queue expected register-file
// writes, a negedge monitor pops and compares every write_enable pulse.
module tb_write_back_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [1:0]  write_back_type_input;
  logic [1:0]  read_status_input;
  logic        load_unsigned_input;
  logic [4:0]  destination_register_number_input;
  logic [31:0] mem_read_data;
  logic        mem_read_valid;
  logic [4:0]  destination_register_number;
  logic [31:0] write_back_data;
  logic        write_enable;
  logic        load_error;
  logic [31:0] retired_count;

  write_back_stage #(.LOAD_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .pc(pc),
    .write_back_type_input(write_back_type_input),
    .read_status_input(read_status_input),
    .load_unsigned_input(load_unsigned_input),
    .destination_register_number_input(destination_register_number_input),
    .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
    .destination_register_number(destination_register_number),
    .write_back_data(write_back_data), .write_enable(write_enable),
    .load_error(load_error), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual rd=%0d data=%h expected no write",
                   destination_register_number, write_back_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_rd", 32'(destination_register_number), 32'(e.rd));
          chk("wb_data", write_back_data, e.data);
        end
      end else begin
        chk("idle_rd_zero", 32'(destination_register_number), 32'd0);
      end
    end
  end

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drive_op(input logic [1:0] t, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] p,
                          input logic exp_we, input logic [31:0] exp_data);
    in_valid = 1'b1;
    write_back_type_input = t;
    read_status_input = 2'b00;
    destination_register_number_input = rd;
    alu_result = alu;
    pc = p;
    if (exp_we) push(rd, exp_data);
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_ret++;
    chk("op_retired", retired_count, exp_ret);
    chk("op_we", 32'(write_enable), 32'(exp_we));
  endtask

  task automatic do_load(input logic [1:0] st, input logic uns, input logic [31:0] alu,
                         input logic [4:0] rd, input int waits,
                         input logic [31:0] word, input logic [31:0] exp_data);
    in_valid = 1'b1;
    write_back_type_input = 2'b10;
    read_status_input = st;
    load_unsigned_input = uns;
    alu_result = alu;
    destination_register_number_input = rd;
    mem_read_valid = 1'b1;          // must be ignored in the accept cycle
    mem_read_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_read_valid = 1'b0;
    write_back_type_input = 2'b00;
    chk("load_busy", 32'(in_ready), 32'd0);
    repeat (waits) begin
      @(posedge clk); #1;
    end
    chk("load_still_busy", 32'(in_ready), 32'd0);
    if (rd != 5'd0) push(rd, exp_data);
    mem_read_valid = 1'b1;
    mem_read_data = word;
    @(posedge clk); #1;
    mem_read_valid = 1'b0;
    exp_ret++;
    chk("load_ready", 32'(in_ready), 32'd1);
    chk("load_retired", retired_count, exp_ret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    alu_result = 32'd0;
    pc = 32'd0;
    write_back_type_input = 2'b00;
    read_status_input = 2'b00;
    load_unsigned_input = 1'b0;
    destination_register_number_input = 5'd0;
    mem_read_data = 32'd0;
    mem_read_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_data", write_back_data, 32'd0);
    chk("rst_err", 32'(load_error), 32'd0);
    chk("rst_retired", retired_count, 32'd0);

    // ALU write, then data holds while idle
    drive_op(2'b01, 5'd5, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678);
    @(posedge clk); #1;
    chk("hold_data", write_back_data, 32'h1234_5678);
    chk("hold_we", 32'(write_enable), 32'd0);

    // Link address, including wrap
    drive_op(2'b11, 5'd1, 32'd0, 32'h0000_0100, 1'b1, 32'h0000_0104);
    drive_op(2'b11, 5'd1, 32'd0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000);

    // mem_read_valid while idle is ignored
    mem_read_valid = 1'b1;
    mem_read_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_read_valid = 1'b0;
    chk("idle_mrv_retired", retired_count, exp_ret);

    // Byte loads at offset 2
    do_load(2'b01, 1'b0, 32'h0000_1002, 5'd7, 3, 32'h0080_0000, 32'hFFFF_FF80);
    do_load(2'b01, 1'b1, 32'h0000_1002, 5'd7, 3, 32'h0080_0000, 32'h0000_0080);
    do_load(2'b01, 1'b1, 32'h0000_2001, 5'd8, 0, 32'hAABB_CCDD, 32'h0000_00CC);
    // Half and word loads
    do_load(2'b10, 1'b0, 32'h0000_0002, 5'd9, 1, 32'h8001_1234, 32'hFFFF_8001);
    do_load(2'b10, 1'b1, 32'h0000_0003, 5'd9, 1, 32'h8001_1234, 32'h0000_8001);
    do_load(2'b10, 1'b0, 32'h0000_0000, 5'd9, 2, 32'h8001_1234, 32'h0000_1234);
    do_load(2'b11, 1'b0, 32'h0000_0003, 5'd10, 2, 32'h8001_1234, 32'h8001_1234);
    // Load to x0: no write but still retires
    do_load(2'b11, 1'b0, 32'h0000_0000, 5'd0, 1, 32'h5555_AAAA, 32'd0);
    // ALU result to x0 and type=10 with status=00 retire without writing
    drive_op(2'b01, 5'd0, 32'h7777_7777, 32'd0, 1'b0, 32'd0);
    drive_op(2'b10, 5'd6, 32'h0000_0040, 32'd0, 1'b0, 32'd0);
    chk("status0_ready", 32'(in_ready), 32'd1);

    // Timeout: 15 wait cycles without data
    in_valid = 1'b1;
    write_back_type_input = 2'b10;
    read_status_input = 2'b11;
    destination_register_number_input = 5'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    write_back_type_input = 2'b00;
    repeat (14) begin
      @(posedge clk); #1;
    end
    chk("to_busy_14", 32'(in_ready), 32'd0);
    chk("to_err_14", 32'(load_error), 32'd0);
    @(posedge clk); #1;
    exp_ret++;
    chk("to_ready", 32'(in_ready), 32'd1);
    chk("to_err", 32'(load_error), 32'd1);
    chk("to_we", 32'(write_enable), 32'd0);
    chk("to_retired", retired_count, exp_ret);

    // Back-to-back: pulses 1,1,0
    in_valid = 1'b1;
    read_status_input = 2'b00;
    write_back_type_input = 2'b01;
    destination_register_number_input = 5'd3;
    alu_result = 32'h0000_0033;
    push(5'd3, 32'h0000_0033);
    @(posedge clk); #1;
    destination_register_number_input = 5'd4;
    alu_result = 32'h0000_0044;
    push(5'd4, 32'h0000_0044);
    @(posedge clk); #1;
    chk("b2b_ready", 32'(in_ready), 32'd1);
    write_back_type_input = 2'b00;
    destination_register_number_input = 5'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_ret = exp_ret + 32'd3;
    chk("b2b_third_we", 32'(write_enable), 32'd0);
    chk("b2b_retired", retired_count, exp_ret);
    chk("err_sticky", 32'(load_error), 32'd1);

    // Reset mid-wait drops the load; a late valid is ignored
    in_valid = 1'b1;
    write_back_type_input = 2'b10;
    read_status_input = 2'b11;
    destination_register_number_input = 5'd14;
    @(posedge clk); #1;
    in_valid = 1'b0;
    write_back_type_input = 2'b00;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = 32'd0;
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_err", 32'(load_error), 32'd0);
    chk("mid_rst_data", write_back_data, 32'd0);
    chk("mid_rst_retired", retired_count, 32'd0);
    mem_read_valid = 1'b1;
    mem_read_data = 32'h1111_2222;
    @(posedge clk); #1;
    mem_read_valid = 1'b0;
    chk("late_valid_we", 32'(write_enable), 32'd0);
    chk("late_valid_retired", retired_count, 32'd0);

    drive_op(2'b01, 5'd2, 32'hABCD_0001, 32'd0, 1'b1, 32'hABCD_0001);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Final pipeline stage of the RISC-V core.
- Accepts retiring instructions from the memory stage and selects the result: ALU result, extended load data, or pc+4.
- Drives the register-file write port that the register-access stage consumes: destination register number plus write-back data.
- Sequences variable-latency load returns with a small FSM, stalls upstream while waiting, and counts retired instructions.

Parameters:
LOAD_TIMEOUT, 16, max cycles spent in WAIT_LOAD before abandoning the load (must be >= 2)

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  synchronous active-high reset
in_valid  input  1  memory stage presents an instruction this cycle
in_ready  output  1  stage can accept; combinational, 1 only in IDLE
alu_result  input  32  ALU result; also the load address (bits [1:0] = byte offset)
pc  input  32  instruction PC
write_back_type_input  input  2  00 none, 01 ALU, 10 load, 11 pc+4 (jal/jalr link)
read_status_input  input  2  00 none, 01 byte, 10 half, 11 word
load_unsigned_input  input  1  1 = zero-extend load, 0 = sign-extend
destination_register_number_input  input  5  rd
mem_read_data  input  32  aligned word returned by data memory
mem_read_valid  input  1  mem_read_data valid this cycle
destination_register_number  output  5  rd to register file; 0 when no write
write_back_data  output  32  value to register file
write_enable  output  1  register-file write strobe
load_error  output  1  sticky; set on load timeout
retired_count  output  32  instructions completed, wraps modulo 2^32

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, wait_cnt=0.
  - All registered outputs cleared: destination_register_number=0, write_back_data=0, write_enable=0, load_error=0, retired_count=0.
  - rst overrides everything, including mid-WAIT_LOAD; the pending load is dropped and no write occurs.
- States: IDLE, WAIT_LOAD. in_ready = (state==IDLE).
- Outputs are registered; write_enable is a pulse per instruction. Back-to-back non-load instructions give consecutive pulses.
- Accept: in IDLE with in_valid=1 at a posedge.
  - Load (type=10 and read_status!=00):
    - Latch alu_result[1:0], read_status, load_unsigned and rd.
    - Go to WAIT_LOAD, wait_cnt=0.
    - write_enable=0 next cycle.
  - Otherwise complete immediately; the next cycle shows:
    - write_enable = (type!=00 && type!=10 && rd!=0).
    - write_back_data: type 01 -> alu_result; 11 -> pc+32'd4 (wraps); 00 or 10 -> 0.
    - destination_register_number = rd when write_enable=1, else 0.
    - retired_count += 1.
- type=10 with read_status=00 is treated as type 00: retires with no write.
- Not accepting (IDLE and in_valid=0): write_enable=0, destination_register_number=0, write_back_data holds its previous value.
- WAIT_LOAD:
  - mem_read_valid is sampled only from the cycle after accept. mem_read_valid in IDLE, or in the accept cycle, is ignored.
  - On mem_read_valid=1, extract and extend, then next cycle:
    - write_enable = (rd!=0), data = extracted value, retired_count += 1.
    - state -> IDLE.
  - Otherwise wait_cnt += 1. When wait_cnt reaches LOAD_TIMEOUT-1 with no valid:
    - load_error=1 (sticky until rst).
    - No write; retired_count += 1.
    - state -> IDLE.
- Load extraction (off = latched alu_result[1:0]):
  - byte: mem_read_data[8*off+7 : 8*off].
  - half: off[1]=0 -> [15:0], off[1]=1 -> [31:16]; off[0] is ignored.
  - word: whole word, off ignored.
  - Sign-extend from the top bit of the field unless load_unsigned=1, in which case zero-extend.
- rd=0 never produces write_enable=1, whatever the type.
- retired_count 32'hFFFFFFFF + 1 -> 0.

Test Plan:
1. ALU write: accept type=01, rd=5, alu_result=32'h1234_5678 -> next cycle write_enable=1, destination_register_number=5, write_back_data=32'h1234_5678, retired_count=1.
2. Link: accept type=11, pc=32'h0000_0100, rd=1 -> write_back_data=32'h0000_0104. Then pc=32'hFFFF_FFFC -> write_back_data=0.
3. Signed byte load: type=10, status=01, unsigned=0, alu_result=...02, rd=7; in_ready=0 for 3 cycles, then mem_read_valid with data 32'h00_80_00_00 -> write_back_data=32'hFFFF_FF80, write_enable=1, in_ready=1. Repeat with unsigned=1 -> 32'h0000_0080.
4. Half/word loads: status=10, off=2, data 32'h8001_1234, signed -> 32'hFFFF_8001. Status=11 -> 32'h8001_1234. Load to rd=0 -> write_enable stays 0, retired_count still increments.
5. Timeout and reset: load with no mem_read_valid for LOAD_TIMEOUT=16 -> load_error=1 after 15 wait cycles, no write, returns to IDLE. A second load with rst asserted mid-wait -> state IDLE, load_error=0, all outputs 0, and a late mem_read_valid is ignored.
6. Back-to-back: in_valid held for ALU rd=3, ALU rd=4, type=00 -> write_enable pulses 1,1,0 with rd 3,4,0; retired_count=3.
